// File: rtl/uart_core.sv
// rtl/uart_core.sv - parametrised full-duplex UART with TX/RX FIFOs, loopback and error pulses
module uart_core #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 loopback,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CPB     = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF    = CPB / 2;
    localparam int CW      = $clog2(CPB);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam bit HAS_PAR = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
    logic [AW:0]          txf_wr_q, txf_rd_q;
    logic                 txf_empty, txf_full, tx_push, tx_load;
    logic [DATA_BITS-1:0] txf_head;

    assign txf_empty = (txf_wr_q == txf_rd_q);
    assign txf_full  = (txf_wr_q[AW] != txf_rd_q[AW]) && (txf_wr_q[AW-1:0] == txf_rd_q[AW-1:0]);
    assign tx_push   = tx_valid && !txf_full;
    assign txf_head  = txf_mem[txf_rd_q[AW-1:0]];
    assign tx_ready  = !txf_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txf_wr_q <= '0;
            txf_rd_q <= '0;
        end else begin
            if (tx_push) txf_wr_q <= txf_wr_q + 1'b1;
            if (tx_load) txf_rd_q <= txf_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) txf_mem[txf_wr_q[AW-1:0]] <= tx_data;
    end

    // ---------------- TX FSM ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        tx_bit_end = (tx_cnt_q == CW'(CPB - 1));
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            S_IDLE: tx_load = !txf_empty;
            S_START: if (tx_bit_end) begin
                tx_d       = tx_sh_q[0];
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                    tx_bit_d = '0;
                    if (HAS_PAR) begin
                        tx_d       = tx_par_q;
                        tx_state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end
                end else begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            S_PARITY: if (tx_bit_end) begin
                tx_d       = 1'b1;
                tx_bit_d   = '0;
                tx_state_d = S_STOP;
            end
            S_STOP: if (tx_bit_end) begin
                if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                    if (!txf_empty) tx_load = 1'b1;
                    else            tx_state_d = S_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Loading from IDLE or straight out of STOP keeps frames gapless.
        if (tx_load) begin
            tx_sh_d    = txf_head;
            tx_par_d   = par_of(txf_head);
            tx_d       = 1'b0;
            tx_cnt_d   = '0;
            tx_state_d = S_START;
        end
    end

    assign tx   = tx_q;
    assign busy = (tx_state_q != S_IDLE) || !txf_empty;

    // ---------------- RX input path ----------------
    logic sync1_q, sync2_q, line_q, line;

    assign line = loopback ? tx_q : sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            line_q  <= line;
        end
    end

    // ---------------- RX FSM ----------------
    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_done, rx_par_bad, rx_push, rx_pop;
    logic                 parity_err_q, frame_err_q, overrun_q;
    logic                 parity_err_d, frame_err_d, overrun_d;
    logic                 rxf_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_sh_q      <= rx_sh_d;
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: if (line_q && !line) begin
                rx_cnt_d   = CW'(1);
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CW'(HALF)) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = line ? S_IDLE : S_DATA;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            default: if (rx_cnt_q == CW'(CPB - 1)) begin
                rx_cnt_d = '0;
                if (rx_state_q == S_DATA) begin
                    rx_sh_d = {line, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 4'(DATA_BITS - 1)) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    else                               rx_bit_d   = rx_bit_q + 4'd1;
                end else if (rx_state_q == S_PARITY) begin
                    rx_par_d   = line;
                    rx_state_d = S_STOP;
                end else begin
                    // Only the first stop bit is checked; any further stop bits look like idle.
                    rx_done    = 1'b1;
                    rx_state_d = S_IDLE;
                end
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
        endcase
        rx_par_bad   = HAS_PAR && (rx_par_q != par_of(rx_sh_q));
        frame_err_d  = rx_done && !line;
        parity_err_d = rx_done && line && rx_par_bad;
        overrun_d    = rx_done && line && !rx_par_bad && rxf_full && !rx_pop;
        rx_push      = rx_done && line && !rx_par_bad && (!rxf_full || rx_pop);
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
    logic [AW:0]          rxf_wr_q, rxf_rd_q, rxf_wr_d, rxf_rd_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;

    assign rx_valid = (rxf_wr_q != rxf_rd_q);
    assign rxf_full = (rxf_wr_q[AW] != rxf_rd_q[AW]) && (rxf_wr_q[AW-1:0] == rxf_rd_q[AW-1:0]);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_data  = rx_data_q;

    // rx_data is a register holding the head as it will be after this edge.
    always_comb begin
        rxf_rd_d  = rx_pop  ? rxf_rd_q + 1'b1 : rxf_rd_q;
        rxf_wr_d  = rx_push ? rxf_wr_q + 1'b1 : rxf_wr_q;
        rx_data_d = rx_data_q;
        if (rxf_rd_d != rxf_wr_q) rx_data_d = rxf_mem[rxf_rd_d[AW-1:0]];
        else if (rx_push)         rx_data_d = rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxf_wr_q  <= '0;
            rxf_rd_q  <= '0;
            rx_data_q <= '0;
        end else begin
            rxf_wr_q  <= rxf_wr_d;
            rxf_rd_q  <= rxf_rd_d;
            rx_data_q <= rx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rxf_mem[rxf_wr_q[AW-1:0]] <= rx_sh_q;
    end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core with randomized frames
module tb_uart_core;
    localparam int CF = 160, BR = 10, DB = 8, PAR = 2, SB = 1, FD = 4;
    localparam int C        = CF / BR;
    localparam int HALF     = C / 2;
    localparam int NBITS    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FRAME    = NBITS * C;
    localparam int STOP_IDX = 1 + DB + ((PAR != 0) ? 1 : 0);
    // cycles from the tx falling edge (loopback) to rx_valid rising
    localparam int RX_LAT   = 1 + HALF + C * STOP_IDX;

    logic          clk = 1'b0, rst = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0, rx_ready = 1'b0, rx = 1'b1, loopback = 1'b0;
    logic          tx_ready, rx_valid, tx, parity_err, frame_err, overrun, busy;
    logic [DB-1:0] rx_data;

    uart_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(DB), .PARITY(PAR),
                .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx(rx), .tx(tx),
        .loopback(loopback), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy));

    always #5 clk = ~clk;

    int            cyc = 0;
    int            checks = 0, errors = 0;
    int            n_perr = 0, n_ferr = 0, n_ovr = 0;
    int            e_perr = 0, e_ferr = 0, e_ovr = 0;
    logic [DB-1:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic par_of(input logic [DB-1:0] d);
        return (PAR == 1) ? ~(^d) : (^d);
    endfunction

    // Monitor: counts error pulse cycles and checks every popped word against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra: got 0x%0h expected no word", rx_data);
                end else begin
                    chk("rx_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no summary after %0d cycles expected finish", cyc);
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DB-1:0] w, input bit expect_rx, output int acc);
        logic r;
        int   n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        if (expect_rx) exp_q.push_back(w);
        forever begin
            r = tx_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 5000) begin
                chk("push_timeout", n, 0);
                break;
            end
        end
        #1;
        tx_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input bit rnd);
        int quiet = 0, n = 0;
        while (quiet < 2 * C && n < 20000) begin
            tick();
            n++;
            if (rnd) rx_ready = 1'($urandom_range(0, 1));
            quiet = busy ? 0 : quiet + 1;
        end
        chk("idle_timeout", (n < 20000) ? 1 : 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        rx_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick(2);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic send_serial(input logic [DB-1:0] d, input logic pb, input logic sb);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(C);
        end
        if (PAR != 0) begin
            rx = pb;
            tick(C);
        end
        rx = sb;
        tick(C);
        rx = 1'b1;
        tick(2 * C);
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_parity_err"}, n_perr, e_perr);
        chk({tag, "_frame_err"},  n_ferr, e_ferr);
        chk({tag, "_overrun"},    n_ovr,  e_ovr);
    endtask

    initial begin
        int p, p0, n, t_low, t_rxv, t_idle, popedge, kind;
        int pa[FD+1];
        logic [DB-1:0] w;

        // reset state
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_pulses", {parity_err, frame_err, overrun}, 0);
        rst = 1'b1;
        tick(2);

        // single loopback word: timing of tx, rx_valid and busy
        loopback = 1'b1;
        rx_ready = 1'b0;
        push_word(8'hA5, 1'b1, p);
        chk("t1_tx_before", tx, 1);
        tick();
        chk("t1_tx_fall", tx, 0);
        t_low = -1; t_rxv = -1; t_idle = -1;
        for (int i = 1; i <= FRAME + 40; i++) begin
            tick();
            if (t_low < 0 && tx)       t_low  = i;
            if (t_rxv < 0 && rx_valid) t_rxv  = i;
            if (t_idle < 0 && !busy)   t_idle = i;
            if (t_rxv >= 0 && t_idle >= 0) break;
        end
        chk("t1_start_len", t_low, C);
        chk("t1_rx_valid_lat", t_rxv, RX_LAT);
        chk("t1_frame_len", t_idle, FRAME);
        chk("t1_rx_head", rx_data, 8'hA5);
        drain();
        chk_errs("t1");

        // back-to-back burst through a depth-4 FIFO
        for (int i = 0; i <= FD; i++) push_word(8'(i + 1), 1'b1, pa[i]);
        chk("t2_tx_ready_full", tx_ready, 0);
        chk("t2_push_span", pa[FD] - pa[0], FD);
        n = 0;
        while (busy && n < 10 * FRAME) begin
            tick();
            n++;
        end
        chk("t2_burst_len", cyc - (pa[0] + 1), (FD + 1) * FRAME);
        tick(C);
        drain();

        // random loopback traffic with random consumer stalls
        for (int k = 0; k < 8; k++) begin
            rx_ready = 1'b1;
            push_word(8'($urandom), 1'b1, p);
            repeat ($urandom_range(0, 40)) begin
                tick();
                rx_ready = 1'($urandom_range(0, 1));
            end
        end
        wait_idle(1'b1);
        drain();
        chk_errs("rand_lb");

        // external rx: bad then good parity, bad stop then good frame
        loopback = 1'b0;
        rx_ready = 1'b1;
        send_serial(8'h03, 1'b1, 1'b1);
        e_perr++;
        chk("t3_no_data", rx_valid, 0);
        exp_q.push_back(8'h03);
        send_serial(8'h03, 1'b0, 1'b1);
        send_serial(8'h5A, par_of(8'h5A), 1'b0);
        e_ferr++;
        exp_q.push_back(8'h5A);
        send_serial(8'h5A, par_of(8'h5A), 1'b1);
        drain();
        chk_errs("t34");

        // random external frames with random error injection
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            kind = $urandom_range(0, 2);
            if (kind == 0) exp_q.push_back(w);
            if (kind == 1) e_perr++;
            if (kind == 2) e_ferr++;
            send_serial(w, par_of(w) ^ (kind == 1), (kind != 2));
        end
        drain();
        chk_errs("rand_rx");

        // overrun with consumer stalled
        loopback = 1'b1;
        rx_ready = 1'b0;
        for (int i = 0; i <= FD; i++) push_word(8'(8'h10 + i), (i < FD), p);
        e_ovr++;
        wait_idle(1'b0);
        chk_errs("t5a");
        chk("t5a_rx_valid", rx_valid, 1);
        drain();

        // a pop on the very edge the last frame completes avoids the overrun
        rx_ready = 1'b0;
        for (int i = 0; i <= FD; i++) push_word(8'(8'h20 + i), 1'b1, pa[i]);
        popedge = pa[0] + 1 + FD * FRAME + RX_LAT;
        while (cyc < popedge - 1) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        wait_idle(1'b0);
        chk_errs("t5b");
        drain();

        // reset in the middle of a TX data bit
        rx_ready = 1'b0;
        push_word(8'h33, 1'b0, p);
        push_word(8'hCC, 1'b0, p);
        tick(FRAME + 3 * C);
        chk("t6_pre_rx_valid", rx_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_tx", tx, 1);
        chk("t6_busy", busy, 0);
        chk("t6_tx_ready", tx_ready, 1);
        chk("t6_rx_valid", rx_valid, 0);
        tick(2);
        rst = 1'b1;
        loopback = 1'b0;
        rx_ready = 1'b1;
        tick(2);
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(4 * C);
        chk("t6_glitch_rx_valid", rx_valid, 0);
        chk("t6_glitch_busy", busy, 0);
        chk_errs("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Parametrised full-duplex UART and successor to the fixed 8N1 loopback pair.
- Configurable data width, parity and stop bits.
- TX and RX FIFOs with valid/ready handshakes.
- Runtime-selectable internal loopback.
- Parity, framing and overrun error reporting.
- Sits between a byte-stream producer/consumer and the serial pins.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 9600, serial bit rate. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division, must be at least 4.
DATA_BITS, 8, data bits per frame, legal range 5..8.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits transmitted: 1 or 2.
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of 2, at least 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
tx_data  input  DATA_BITS  word to transmit.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  TX FIFO can accept a word (not full).
rx_data  output  DATA_BITS  head of the RX FIFO.
rx_valid  output  1  RX FIFO is not empty.
rx_ready  input  1  consumer accepts rx_data.
rx  input  1  serial input pin; asynchronous.
tx  output  1  serial output pin.
loopback  input  1  1 = receiver takes the internal tx line instead of the rx pin.
parity_err  output  1  one-cycle pulse: frame dropped for bad parity.
frame_err  output  1  one-cycle pulse: frame dropped because the stop bit sampled 0.
overrun  output  1  one-cycle pulse: good frame dropped because the RX FIFO was full.
busy  output  1  TX FSM not idle, or TX FIFO not empty.

Behaviour:
- Reset (rst low): takes effect immediately, including mid-frame.
  - tx=1, busy=0, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0.
  - FIFO pointers cleared, both FSMs go to IDLE, synchroniser flops set to 1.
- Handshakes:
  - TX push on tx_valid&&tx_ready.
  - RX pop on rx_valid&&rx_ready. A pop while empty has no effect.
  - rx_data is the registered FIFO head and is stable while rx_valid=1 and no pop occurs.
- Frame format on the line: idle 1, start 0, DATA_BITS LSB first, optional parity bit, STOP_BITS of 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- Parity bit value:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- TX FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty: pop the word and go to START on the next edge. tx falls in the cycle after the word is written into an empty FIFO.
  - At the end of STOP with the FIFO non-empty: go directly to START, so frames run back-to-back with no idle gap.
  - Frame length in cycles: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT.
- RX input path: the rx pin passes through a 2-flop synchroniser. The loopback mux selects between the synchronised rx and the internal tx line, so loopback has no synchroniser delay.
- RX FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: a 1->0 transition on the line enters START.
  - START: sample at CLKS_PER_BIT/2. If the sample is 1 (glitch), return to IDLE with no flag.
  - DATA, PARITY and STOP: each sampled one CLKS_PER_BIT after the previous sample.
  - Only the first stop bit is checked. A second stop bit is treated as idle.
- Frame completion at the stop-bit sample; checks apply in this priority:
  - Stop bit 0: frame_err pulse, frame dropped.
  - Else parity mismatch: parity_err pulse, frame dropped.
  - Else RX FIFO full with no pop in the same cycle: overrun pulse, frame dropped, FIFO contents unchanged.
  - Else push. rx_valid rises in the cycle after the stop-bit sample.
- Pulse timing: error pulses are one cycle wide, asserted in the cycle after the stop-bit sample.
- Simultaneous push and pop:
  - On a full RX FIFO: the pop frees the slot and the push is accepted, with no overrun.
  - On the TX FIFO when full: no push can occur, since tx_ready=0.
- Changing loopback mid-frame: the current RX frame may be corrupted, and any resulting error is reported normally. TX is unaffected.

Test Plan:
1. CLOCK_FREQ=160, BAUD_RATE=10 (CLKS_PER_BIT=16), 8N1, loopback=1, push 0xA5 -> tx falls one cycle after the push and stays low 16 cycles; frame lasts 160 cycles; rx_valid rises with rx_data=0xA5; no error pulses; busy returns to 0.
2. FIFO_DEPTH=4, push 0x01,0x02,0x03,0x04,0x05 back-to-back -> tx_ready drops after the 5th accepted push (1 word already moved to the FSM, 4 queued); frames leave with no idle gap; RX order is 01..05.
3. PARITY=2, loopback=0, drive rx with data 0x03 and parity bit 1 -> parity_err pulses once, rx_valid stays 0. The same frame with parity bit 0 -> rx_data=0x03.
4. Drive rx with a frame for 0x5A whose stop bit is 0 -> frame_err pulse, nothing pushed; a following good 0x5A is received correctly.
5. rx_ready=0, loopback=1, send FIFO_DEPTH+1 words 0x10.. -> overrun pulses on the last frame; popping yields 0x10..0x10+FIFO_DEPTH-1. Then repeat with a pop coinciding with the completion of frame FIFO_DEPTH+1 -> no overrun, that word is stored.
6. Assert rst low mid-DATA on tx -> tx=1 and busy=0 immediately, both FIFOs empty. After release, an rx low pulse of 5 cycles is ignored with no flags and no data.
